board_cursor_ctrl: RTL and testbench
====================================

BOARD_CURSOR_CTRL -- requirements
Module: board_cursor_ctrl

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 1000: consecutive stable synchronized samples needed to accept a button level change.
REQ-002 SHALL have parameter SQ_PX, default 34: board square size in pixels.
REQ-003 SHALL have parameter ORG_X, default 43: pixel column of square file 0.
REQ-004 SHALL have parameter ORG_Y, default 11: pixel row of square rank 0.
REQ-005 SHALL have ports, one per line:
- clk  input  1  system clock; all state changes on the rising edge.
- rstn  input  1  reset, asynchronous, active-low.
- btn_left_n / btn_up_n / btn_down_n / btn_right_n / btn_sel_n  input  1 each  raw asynchronous pushbuttons, active-low.
- cur_file  output  3  cursor column, 0..7.
- cur_rank  output  3  cursor row, 0..7, 0 = top.
- cur_x  output  10  ORG_X + cur_file*SQ_PX, registered.
- cur_y  output  10  ORG_Y + cur_rank*SQ_PX, registered.
- sel_active  output  1  source square picked, move pending.
- mv_valid  output  1  move request valid.
- mv_ready  input  1  game logic accepts the move.
- mv_src  output  6  {rank,file} of picked square.
- mv_dst  output  6  {rank,file} of destination square.

Function
REQ-006 SHALL pass each button through a 2-flop synchronizer.
REQ-007 SHALL keep a per-button debounced level and counter: the counter clears whenever the synchronized level equals the debounced level; otherwise it increments, and at DEB_CYCLES the debounced level flips and the counter clears.
REQ-008 SHALL generate a one-cycle press event on each debounced 1->0 transition; a held button SHALL give exactly one event, with no auto-repeat; releases SHALL give no event.
REQ-009 SHALL accept at most one event per cycle, priority sel > up > down > left > right; lower-priority events in the same cycle SHALL be dropped, not queued.
REQ-010 SHALL update cur_file/cur_rank on the clock edge after the accepted event: up rank-1, down rank+1, left file-1, right file+1.
REQ-011 SHALL saturate at the board edges: a move past 0 or 7 leaves the coordinate unchanged, with no wrap-around.
REQ-012 SHALL update cur_x/cur_y one cycle after cur_file/cur_rank changes; the 10-bit result cannot overflow (max 281).
REQ-013 SHALL implement a state machine with states IDLE, PICKED, WAIT_ACK:
- IDLE: on sel event, load mv_src = {cur_rank,cur_file}, set sel_active=1, go to PICKED.
- PICKED: moves allowed. A sel event with cursor == mv_src cancels (sel_active=0, go to IDLE). A sel event with cursor != mv_src loads mv_dst = cursor, sets mv_valid=1, goes to WAIT_ACK.
- WAIT_ACK: mv_valid, mv_src and mv_dst held stable. All button events are dropped. On mv_ready=1 sampled at an edge: mv_valid=0, sel_active=0, go to IDLE on that edge.
REQ-014 SHALL assert mv_valid independent of mv_ready; mv_ready outside WAIT_ACK SHALL be ignored.
REQ-015 SHALL accept a move event and a sel event on different cycles of PICKED in either order; only the cursor position at the sel event defines mv_dst.

Reset
REQ-016 rstn low SHALL immediately force:
- cur_file=0, cur_rank=0, cur_x=ORG_X, cur_y=ORG_Y.
- state IDLE, sel_active=0, mv_valid=0, mv_src=0, mv_dst=0.
- synchronizer flops and debounced levels =1 (released), debounce counters =0.
REQ-017 Reset asserted in PICKED or WAIT_ACK SHALL discard the pending move; a button held through reset release SHALL produce no event until it is released and pressed again.

Verification (DEB_CYCLES=4)
REQ-018 Right press held 20 cycles -> single event; cur_file 0->1, cur_x 43->77 one cycle after the cur_file update.
REQ-019 Up press at rank 0; eight down presses -> rank stays 0, then saturates at 7 (cur_y=249); a ninth down press leaves it at 7.
REQ-020 Button bouncing 1/0 every 2 cycles for 20 cycles, then stable low -> exactly one event, after 4 stable cycles.
REQ-021 Up and left debounced on the same cycle -> rank changes, file unchanged; sel and right together -> sel handled, file unchanged.
REQ-022 sel at (0,0), right x2, sel -> mv_valid=1, mv_src=0, mv_dst=2; mv_ready held low 10 cycles with presses -> outputs stable and presses ignored; mv_ready=1 -> IDLE, mv_valid=0 on that edge.
REQ-023 sel, then sel at the same square -> cancel, no mv_valid. sel, then rstn pulse in WAIT_ACK -> all outputs at reset values.

Source files
------------

// File: rtl/board_cursor_ctrl.sv
// Chess-board cursor controller: debounced pushbuttons move a cursor square and
// a pick/place state machine emits {rank,file} move requests to the game logic.
module board_cursor_ctrl #(
  parameter int DEB_CYCLES = 1000,
  parameter int SQ_PX      = 34,
  parameter int ORG_X      = 43,
  parameter int ORG_Y      = 11
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       btn_left_n,
  input  logic       btn_up_n,
  input  logic       btn_down_n,
  input  logic       btn_right_n,
  input  logic       btn_sel_n,
  output logic [2:0] cur_file,
  output logic [2:0] cur_rank,
  output logic [9:0] cur_x,
  output logic [9:0] cur_y,
  output logic       sel_active,
  output logic       mv_valid,
  input  logic       mv_ready,
  output logic [5:0] mv_src,
  output logic [5:0] mv_dst
);

  localparam int              CW       = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [9:0]      ORG_X10  = 10'(ORG_X);
  localparam logic [9:0]      ORG_Y10  = 10'(ORG_Y);
  localparam logic [9:0]      SQ10     = 10'(SQ_PX);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] PICKED   = 2'd1;
  localparam logic [1:0] WAIT_ACK = 2'd2;

  // Button bit order: 0 sel, 1 up, 2 down, 3 left, 4 right
  logic [4:0]    raw;
  logic [4:0]    sync1;
  logic [4:0]    sync2;
  logic [4:0]    deb;
  logic [4:0]    armed;
  logic [4:0]    press;
  logic [1:0]    prime;
  logic [CW-1:0] cnt [5];

  assign raw = {btn_right_n, btn_left_n, btn_down_n, btn_up_n, btn_sel_n};

  // A button is armed only once it has been seen released after the
  // synchronizer refilled, so a press held through reset gives no event.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1 <= '1;
      sync2 <= '1;
      deb   <= '1;
      armed <= '0;
      press <= '0;
      prime <= '0;
      for (int unsigned i = 0; i < 5; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      prime <= {prime[0], 1'b1};
      press <= '0;
      for (int unsigned i = 0; i < 5; i++) begin
        if (prime[1] && sync2[i]) armed[i] <= 1'b1;
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          cnt[i]   <= '0;
          deb[i]   <= ~deb[i];
          press[i] <= deb[i] & armed[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  logic [1:0] state;
  logic       allow;
  logic       ev_sel;
  logic       ev_up;
  logic       ev_down;
  logic       ev_left;
  logic       ev_right;
  logic [5:0] cursor;

  always_comb begin
    allow    = (state != WAIT_ACK);
    ev_sel   = allow & press[0];
    ev_up    = allow & ~press[0] & press[1];
    ev_down  = allow & ~press[0] & ~press[1] & press[2];
    ev_left  = allow & ~press[0] & ~press[1] & ~press[2] & press[3];
    ev_right = allow & ~press[0] & ~press[1] & ~press[2] & ~press[3] & press[4];
    cursor   = {cur_rank, cur_file};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cur_file <= '0;
      cur_rank <= '0;
    end else begin
      if (ev_up && cur_rank != 3'd0)    cur_rank <= cur_rank - 3'd1;
      if (ev_down && cur_rank != 3'd7)  cur_rank <= cur_rank + 3'd1;
      if (ev_left && cur_file != 3'd0)  cur_file <= cur_file - 3'd1;
      if (ev_right && cur_file != 3'd7) cur_file <= cur_file + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cur_x <= ORG_X10;
      cur_y <= ORG_Y10;
    end else begin
      cur_x <= ORG_X10 + 10'(cur_file) * SQ10;
      cur_y <= ORG_Y10 + 10'(cur_rank) * SQ10;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      sel_active <= 1'b0;
      mv_valid   <= 1'b0;
      mv_src     <= '0;
      mv_dst     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ev_sel) begin
            mv_src     <= cursor;
            sel_active <= 1'b1;
            state      <= PICKED;
          end
        end
        PICKED: begin
          if (ev_sel) begin
            if (cursor == mv_src) begin
              sel_active <= 1'b0;
              state      <= IDLE;
            end else begin
              mv_dst   <= cursor;
              mv_valid <= 1'b1;
              state    <= WAIT_ACK;
            end
          end
        end
        WAIT_ACK: begin
          if (mv_ready) begin
            mv_valid   <= 1'b0;
            sel_active <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          sel_active <= 1'b0;
          mv_valid   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_board_cursor_ctrl.sv
// Self-checking bench for board_cursor_ctrl: directed scenarios plus random
// press/ack sequences compared against a transaction-level board model.
module tb_board_cursor_ctrl;

  localparam int OX = 43;
  localparam int OY = 11;
  localparam int SQ = 34;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [4:0] btn_n = '1;  // 0 sel, 1 up, 2 down, 3 left, 4 right
  logic       mv_ready = 1'b0;
  logic [2:0] cur_file, cur_rank;
  logic [9:0] cur_x, cur_y;
  logic       sel_active, mv_valid;
  logic [5:0] mv_src, mv_dst;

  board_cursor_ctrl #(.DEB_CYCLES(4)) dut (
    .clk(clk), .rstn(rstn),
    .btn_left_n(btn_n[3]), .btn_up_n(btn_n[1]), .btn_down_n(btn_n[2]),
    .btn_right_n(btn_n[4]), .btn_sel_n(btn_n[0]),
    .cur_file(cur_file), .cur_rank(cur_rank), .cur_x(cur_x), .cur_y(cur_y),
    .sel_active(sel_active), .mv_valid(mv_valid), .mv_ready(mv_ready),
    .mv_src(mv_src), .mv_dst(mv_dst)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Board model: state 0 idle, 1 source picked, 2 awaiting acknowledge
  int m_file, m_rank, m_state, m_src, m_dst;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic void model_reset();
    m_file = 0; m_rank = 0; m_state = 0; m_src = 0; m_dst = 0;
  endfunction

  function automatic void model_apply(input logic [4:0] m);
    int pos;
    pos = m_rank * 8 + m_file;
    if (m_state == 2) return;
    if (m[0]) begin
      if (m_state == 0) begin m_src = pos; m_state = 1; end
      else if (pos == m_src) m_state = 0;
      else begin m_dst = pos; m_state = 2; end
    end else if (m[1]) begin if (m_rank > 0) m_rank--; end
    else if (m[2]) begin if (m_rank < 7) m_rank++; end
    else if (m[3]) begin if (m_file > 0) m_file--; end
    else if (m[4]) begin if (m_file < 7) m_file++; end
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".file"}, 32'(cur_file), 32'(m_file));
    check({tag, ".rank"}, 32'(cur_rank), 32'(m_rank));
    check({tag, ".x"}, 32'(cur_x), 32'(OX + m_file * SQ));
    check({tag, ".y"}, 32'(cur_y), 32'(OY + m_rank * SQ));
    check({tag, ".sel_active"}, 32'(sel_active), 32'(m_state != 0));
    check({tag, ".mv_valid"}, 32'(mv_valid), 32'(m_state == 2));
    check({tag, ".mv_src"}, 32'(mv_src), 32'(m_src));
    check({tag, ".mv_dst"}, 32'(mv_dst), 32'(m_dst));
  endtask

  task automatic press(input logic [4:0] mask, input int hold);
    btn_n = ~mask;
    tick(hold);
    btn_n = '1;
    tick(10);
    model_apply(mask);
  endtask

  task automatic ack();
    mv_ready = 1'b1;
    tick(1);
    mv_ready = 1'b0;
    if (m_state == 2) m_state = 0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick(2);
    rstn = 1'b1;
    model_reset();
    tick(1);
  endtask

  initial begin
    int fchg, xchg, f_at, x_at, prev_f, prev_x, rsel;
    logic [4:0] mask;
    model_reset();
    tick(2);
    check_all("reset");
    rstn = 1'b1;
    tick(2);

    // Held right press: one event, pixel column follows a cycle later
    fchg = 0; xchg = 0; f_at = -1; x_at = -1;
    prev_f = int'(cur_file); prev_x = int'(cur_x);
    btn_n[4] = 1'b0;
    for (int c = 0; c < 24; c++) begin
      tick(1);
      if (int'(cur_file) != prev_f) begin fchg++; f_at = c; end
      if (int'(cur_x) != prev_x) begin xchg++; x_at = c; end
      prev_f = int'(cur_file); prev_x = int'(cur_x);
    end
    btn_n = '1;
    tick(10);
    model_apply(5'b10000);
    check("hold.file_changes", 32'(fchg), 32'd1);
    check("hold.x_lag", 32'(x_at - f_at), 32'd1);
    check_all("hold");

    // Up at rank 0 saturates; eight downs reach and hold rank 7
    press(5'b00010, 8);
    check_all("up_sat");
    for (int k = 0; k < 9; k++) press(5'b00100, 9);
    check_all("down_sat");
    check("down_sat.y249", 32'(cur_y), 32'd249);

    // Bouncing right: nothing until stable low, then exactly one step
    fchg = 0; f_at = -1; prev_f = int'(cur_file);
    for (int c = 0; c < 34; c++) begin
      btn_n[4] = (c < 20) ? 1'(((c / 2) % 2)) : 1'b0;
      tick(1);
      if (int'(cur_file) != prev_f) begin fchg++; f_at = c; end
      prev_f = int'(cur_file);
    end
    btn_n = '1;
    tick(10);
    model_apply(5'b10000);
    check("bounce.changes", 32'(fchg), 32'd1);
    check("bounce.after_stable", 32'(f_at >= 24), 32'd1);
    check_all("bounce");

    // Simultaneous presses resolved by priority
    press(5'b01010, 9);
    check_all("up_left");
    press(5'b10001, 9);
    check_all("sel_right");
    press(5'b00001, 9);
    check_all("cancel");
    check("cancel.no_valid", 32'(mv_valid), 32'd0);

    // Full move from (0,0) to (0,2) with a stalled acknowledge
    do_reset();
    press(5'b00001, 9);
    press(5'b10000, 9);
    press(5'b10000, 9);
    press(5'b00001, 9);
    check_all("move");
    check("move.dst2", 32'(mv_dst), 32'd2);
    press(5'b00100, 9);
    press(5'b00001, 9);
    check_all("wait_ignore");
    ack();
    check("ack.valid_low", 32'(mv_valid), 32'd0);
    check_all("ack");

    // Reset while waiting for acknowledge discards the move immediately
    press(5'b00001, 9);
    press(5'b10000, 9);
    press(5'b00001, 9);
    check_all("pre_rst");
    #2 rstn = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    tick(2);
    rstn = 1'b1;
    tick(1);

    // Button held through reset release gives no event until re-pressed
    btn_n[4] = 1'b0;
    tick(2);
    do_reset();
    tick(20);
    check_all("held_rst");
    btn_n = '1;
    tick(10);
    press(5'b10000, 9);
    check_all("after_held");

    // Random presses, combos and acknowledges
    for (int it = 0; it < 60; it++) begin
      rsel = int'($urandom_range(0, 7));
      if (rsel <= 4) press(5'(1 << rsel), int'($urandom_range(8, 14)));
      else if (rsel == 5) ack();
      else begin
        mask = 5'($urandom_range(1, 31));
        press(mask, int'($urandom_range(8, 14)));
      end
      check_all("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
